apb_register_bank: RTL and testbench

APB responder (slave) at the receive end of the register-programming bus that the testbench stimulus drives. It decodes writes into the control register, the configuration registers (white pixel, Np, Nw, six random parameters) and a pixel window that forwards primary-image and watermark pixels to an external pixel memory. It issues a one-cycle start pulse to the watermark datapath, tracks busy/done status through Image_Done, and write-protects configuration while an image is being processed.

---
 rtl/apb_register_bank.sv | 122 ++++++++++++
 tb/tb_apb_register_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_register_bank.sv
// APB register bank: control/status, configuration registers and a
// write-only pixel window that forwards pixels to external memory.
module apb_register_bank #(
  parameter int Amba_Addr_Depth = 10,
  parameter int Amba_Word       = 16,
  parameter int Data_Depth      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [Amba_Addr_Depth-1:0]   PADDR,
  input  logic [Amba_Word-1:0]         PWDATA,
  output logic [Amba_Word-1:0]         PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic                         Image_Done,
  output logic                         start,
  output logic                         busy,
  output logic [Amba_Word-1:0]         white_pixel,
  output logic [Amba_Word-1:0]         np,
  output logic [Amba_Word-1:0]         nw,
  output logic [6*Amba_Word-1:0]       params,
  output logic                         mem_we,
  output logic [Amba_Addr_Depth-1:0]   mem_addr,
  output logic [Data_Depth-1:0]        mem_wdata
);

  localparam logic [Amba_Addr_Depth-1:0] PIX_BASE = Amba_Addr_Depth'(10);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic                 done;
  logic [Amba_Word-1:0] cfg [1:9];

  logic wr, is_ctrl, is_cfg, is_pix;
  logic start_req, start_ok, start_rej;

  assign wr      = PSEL & PENABLE & PWRITE;
  assign is_ctrl = (PADDR == '0);
  assign is_cfg  = !is_ctrl && (PADDR < PIX_BASE);
  assign is_pix  = (PADDR >= PIX_BASE);

  // Image_Done in the same cycle frees the datapath, so a start request
  // is judged against busy already cleared; config/pixel protection is not.
  assign start_req = wr & is_ctrl & PWDATA[0];
  assign start_ok  = start_req & (~busy | Image_Done);
  assign start_rej = start_req & busy & ~Image_Done;

  assign busy    = (state == RUN);
  assign PREADY  = 1'b1;
  assign PSLVERR = start_rej | (wr & busy & (is_cfg | is_pix));

  assign white_pixel = cfg[1];
  assign np          = cfg[2];
  assign nw          = cfg[3];
  always_comb begin
    params = '0;
    for (int unsigned i = 0; i < 6; i++)
      params[i*Amba_Word +: Amba_Word] = cfg[4+i];
  end

  // Status FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Status FSM next state: completion first, then a new start
  always_comb begin
    state_nxt = state;
    if (state == RUN && Image_Done) state_nxt = IDLE;
    if (start_ok)                   state_nxt = RUN;
  end

  // Start pulse, sticky done flag and pixel forwarding
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start     <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      start  <= start_ok;
      mem_we <= wr & is_pix & ~busy;
      if (wr && is_pix && !busy) begin
        mem_addr  <= PADDR - PIX_BASE;
        mem_wdata <= PWDATA[Data_Depth-1:0];
      end
      if (wr && is_ctrl)  done <= 1'b0;
      else if (Image_Done) done <= 1'b1;
    end
  end

  // Configuration registers, write-protected while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 1; i <= 9; i++) cfg[i] <= '0;
    end else if (wr && is_cfg && !busy) begin
      for (int unsigned i = 1; i <= 9; i++)
        if (PADDR == Amba_Addr_Depth'(i)) cfg[i] <= PWDATA;
    end
  end

  // Combinational read mux; pixel window and start bit read as zero
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (is_ctrl) begin
        PRDATA[1] = busy;
        PRDATA[2] = done;
      end else if (is_cfg) begin
        for (int unsigned i = 1; i <= 9; i++)
          if (PADDR == Amba_Addr_Depth'(i)) PRDATA = cfg[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_register_bank.sv
// Scoreboard bench for apb_register_bank: stimulus queues expectations,
// a negedge monitor consumes them as the DUT presents outputs.
module tb_apb_register_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [9:0]  PADDR = '0;
  logic [15:0] PWDATA = '0;
  logic [15:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        Image_Done = 1'b0;
  logic        start, busy;
  logic [15:0] white_pixel, np, nw;
  logic [95:0] params;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;

  apb_register_bank #(.Amba_Addr_Depth(10), .Amba_Word(16), .Data_Depth(8)) dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .Image_Done(Image_Done), .start(start), .busy(busy),
    .white_pixel(white_pixel), .np(np), .nw(nw), .params(params),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  typedef enum {K_WHITE, K_NP, K_NW, K_PARAMS, K_BUSY, K_RESET} kind_t;
  typedef struct { kind_t k; logic [127:0] v; } chk_t;

  chk_t        chk_q[$];
  logic        err_q[$];
  logic [15:0] rd_q[$];
  logic [17:0] pix_q[$];
  logic        start_q[$];
  logic        finish_req = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Monitor: consume expectations whenever the DUT presents a response
  always @(negedge clk) begin
    chk_t c;
    logic [17:0] p;
    cyc++;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.k)
        K_WHITE:  check("white_pixel", white_pixel, c.v);
        K_NP:     check("np", np, c.v);
        K_NW:     check("nw", nw, c.v);
        K_PARAMS: check("params", params, c.v);
        K_BUSY:   check("busy", busy, c.v);
        K_RESET: begin
          check("reset_outputs_zero", |{start, busy, mem_we, PSLVERR, PRDATA, white_pixel,
                np, nw, params, mem_addr, mem_wdata}, c.v);
          check("reset_pready", PREADY, 1'b1);
        end
        default: ;
      endcase
    end
    if (rst && PSEL && PENABLE) begin
      if (PWRITE) begin
        if (err_q.size() == 0) check("pslverr_unexpected_access", 1'b1, 1'b0);
        else check("pslverr", PSLVERR, err_q.pop_front());
      end else begin
        if (rd_q.size() == 0) check("prdata_unexpected_read", 1'b1, 1'b0);
        else check("prdata", PRDATA, rd_q.pop_front());
      end
    end
    if (mem_we) begin
      if (pix_q.size() == 0) check("mem_we_unexpected", mem_we, 1'b0);
      else begin
        p = pix_q.pop_front();
        check("mem_addr_wdata", {mem_addr, mem_wdata}, p);
      end
    end
    if (start) begin
      if (start_q.size() == 0) check("start_unexpected", start, 1'b0);
      else check("start_pulse", start, start_q.pop_front());
    end
    if (finish_req) begin
      check("pending_pixels", pix_q.size(), 0);
      check("pending_starts", start_q.size(), 0);
      check("pending_pslverr", err_q.size(), 0);
      check("pending_reads", rd_q.size(), 0);
      summary();
    end else if (cyc > 20000) begin
      check("watchdog_timeout", 1'b1, 1'b0);
      summary();
    end
  end

  task automatic push_chk(input kind_t k, input logic [127:0] v);
    chk_t c;
    c.k = k;
    c.v = v;
    chk_q.push_back(c);
  endtask

  // Two-phase write; the access phase optionally coincides with Image_Done
  task automatic apb_write(input logic [9:0] a, input logic [15:0] d, input logic err,
                           input logic with_done = 1'b0);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    Image_Done = with_done;
    err_q.push_back(err);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; Image_Done = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] a, input logic [15:0] exp);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 push_chk(K_RESET, 1'b0);
    settle();
    rst = 1'b1;

    // Reset mid-run
    start_q.push_back(1'b1);
    apb_write(10'd0, 16'd1, 1'b0);
    push_chk(K_BUSY, 1'b1);
    settle();
    rst = 1'b0;
    push_chk(K_RESET, 1'b0);
    settle();
    rst = 1'b1;
    apb_read(10'd0, 16'h0000);

    // Configuration
    apb_write(10'd1, 16'd255, 1'b0);
    apb_write(10'd2, 16'd8, 1'b0);
    apb_write(10'd3, 16'd4, 1'b0);
    apb_write(10'd4, 16'd3, 1'b0);
    apb_write(10'd5, 16'd7, 1'b0);
    apb_write(10'd6, 16'd1, 1'b0);
    apb_write(10'd7, 16'd9, 1'b0);
    apb_write(10'd8, 16'd2, 1'b0);
    apb_write(10'd9, 16'd5, 1'b0);
    push_chk(K_WHITE, 16'd255);
    push_chk(K_NP, 16'd8);
    push_chk(K_NW, 16'd4);
    push_chk(K_PARAMS, 96'h0005_0002_0009_0001_0007_0003);
    apb_read(10'd1, 16'd255);
    apb_read(10'd3, 16'd4);
    apb_read(10'd9, 16'd5);
    apb_read(10'd12, 16'd0);

    // Setup phase without enable: no effect
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'd2; PWDATA = 16'd99;
    repeat (2) settle();
    PSEL = 1'b0;
    push_chk(K_NP, 16'd8);

    // Pixel window
    pix_q.push_back({10'd0, 8'h37});
    apb_write(10'd10, 16'h0137, 1'b0);
    pix_q.push_back({10'd64, 8'd200});
    apb_write(10'd74, 16'd200, 1'b0);

    // Start and write protection
    start_q.push_back(1'b1);
    apb_write(10'd0, 16'd1, 1'b0);
    push_chk(K_BUSY, 1'b1);
    apb_read(10'd0, 16'h0002);
    apb_write(10'd2, 16'd16, 1'b1);
    push_chk(K_NP, 16'd8);
    apb_write(10'd12, 16'd5, 1'b1);

    // Done
    settle();
    Image_Done = 1'b1;
    settle();
    Image_Done = 1'b0;
    push_chk(K_BUSY, 1'b0);
    apb_read(10'd0, 16'h0004);
    apb_write(10'd0, 16'd0, 1'b0);
    apb_read(10'd0, 16'h0000);
    start_q.push_back(1'b1);
    apb_write(10'd0, 16'd1, 1'b0);
    apb_write(10'd0, 16'd1, 1'b1);
    push_chk(K_BUSY, 1'b1);

    // Collision: Image_Done with a start write on the same edge
    start_q.push_back(1'b1);
    apb_write(10'd0, 16'd1, 1'b0, 1'b1);
    push_chk(K_BUSY, 1'b1);
    apb_read(10'd0, 16'h0002);

    repeat (3) settle();
    finish_req = 1'b1;
  end

endmodule
